// File: rtl/hwpe_stream_tcdm_fetch_realign_if.sv
// Generic hwpe valid/ready stream carrying data plus byte strobes.
// master drives valid/data/strb, slave drives ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport master (output valid, data, strb, input ready);
  modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_tcdm_fetch_realign.sv
// Issues TCDM reads from address-generator tokens and realigns returned words into a 32-bit stream.
// Optional stall counter enabled by defining HWPE_STREAM_FETCH_STALL_CNT_EN.
module hwpe_stream_tcdm_fetch_realign #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          test_mode_i,
  input  logic                          enable_i,
  input  logic                          clear_i,
  hwpe_stream_intf_stream.slave         addr_i,
  output logic                          tcdm_req_o,
  input  logic                          tcdm_gnt_i,
  output logic [31:0]                   tcdm_add_o,
  input  logic [31:0]                   tcdm_r_data_i,
  input  logic                          tcdm_r_valid_i,
  hwpe_stream_intf_stream.master        data_o,
  output logic                          busy_o,
  output logic [31:0]                   stall_cnt_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned UW = CW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [UW-1:0] used_t;
  typedef enum logic {ST_FRESH, ST_CARRY} realign_state_t;

  realign_state_t state_q, state_n;

  logic [6:0]    meta_q [FIFO_DEPTH];
  logic [PW-1:0] meta_wr_q, meta_rd_q;
  logic [31:0]   out_mem_q [FIFO_DEPTH];
  logic [PW-1:0] out_wr_q, out_rd_q;
  cnt_t          out_cnt_q, inflight_q, drop_q;
  logic [31:0]   carry_q, carry_n;
  logic [1:0]    off_q, off_n;

  used_t       used;
  logic        req, grant, rsp_live, rsp_drop, push, pop;
  logic [31:0] push_data;
  logic [63:0] shifted;
  logic        m_mis, m_first, m_last;
  logic [3:0]  m_strb;
  logic        unused_sig;

  function automatic logic [1:0] trailing_zeros(input logic [3:0] s);
    casez (s)
      4'b???1: trailing_zeros = 2'd0;
      4'b??10: trailing_zeros = 2'd1;
      4'b?100: trailing_zeros = 2'd2;
      4'b1000: trailing_zeros = 2'd3;
      default: trailing_zeros = 2'd0;
    endcase
  endfunction

  assign unused_sig = ^{test_mode_i, addr_i.data};

  // Credits cover both in-flight reads and buffered output words, so a returning read always has room.
  assign used       = used_t'(inflight_q) + used_t'(out_cnt_q);
  assign req        = addr_i.valid & enable_i & ~clear_i & (drop_q == '0) & (used < used_t'(FIFO_DEPTH));
  assign grant      = req & tcdm_gnt_i;
  assign tcdm_req_o = req;
  assign tcdm_add_o = req ? {addr_i.data[29:0], 2'b00} : '0;
  assign addr_i.ready = grant;

  assign rsp_drop = tcdm_r_valid_i & (drop_q != '0);
  assign rsp_live = tcdm_r_valid_i & (drop_q == '0) & (inflight_q != '0);
  assign {m_mis, m_first, m_last, m_strb} = meta_q[meta_rd_q];

  assign shifted = {tcdm_r_data_i, carry_q} >> {off_q, 3'b000};

  always_comb begin
    push      = 1'b0;
    push_data = tcdm_r_data_i;
    state_n   = state_q;
    carry_n   = carry_q;
    off_n     = off_q;
    if (rsp_live) begin
      if (!m_mis) begin
        push = 1'b1;
      end else if (m_first) begin
        off_n   = trailing_zeros(m_strb);
        carry_n = tcdm_r_data_i;
        state_n = ST_CARRY;
      end else begin
        push      = 1'b1;
        push_data = shifted[31:0];
        if (m_last) begin
          carry_n = '0;
          off_n   = '0;
          state_n = ST_FRESH;
        end else begin
          carry_n = tcdm_r_data_i;
        end
      end
    end
  end

  assign data_o.valid = (out_cnt_q != '0);
  assign data_o.data  = out_mem_q[out_rd_q];
  assign data_o.strb  = '1;
  assign pop          = data_o.valid & data_o.ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      state_q <= ST_FRESH;
    else if (clear_i) state_q <= ST_FRESH;
    else              state_q <= state_n;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        meta_q[i]    <= '0;
        out_mem_q[i] <= '0;
      end
      meta_wr_q  <= '0;
      meta_rd_q  <= '0;
      out_wr_q   <= '0;
      out_rd_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      carry_q    <= '0;
      off_q      <= '0;
    end else if (clear_i) begin
      meta_wr_q  <= '0;
      meta_rd_q  <= '0;
      out_wr_q   <= '0;
      out_rd_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= '0;
      carry_q    <= '0;
      off_q      <= '0;
      // Reads still owed by the TCDM are discarded as they return; one may be returning right now.
      drop_q <= drop_q + inflight_q - cnt_t'(rsp_live | rsp_drop);
    end else begin
      if (grant) begin
        meta_q[meta_wr_q] <= {addr_i.data[32], addr_i.data[31], addr_i.data[30], addr_i.strb[3:0]};
        meta_wr_q         <= meta_wr_q + 1'b1;
      end
      if (rsp_live) meta_rd_q <= meta_rd_q + 1'b1;
      if (rsp_drop) drop_q <= drop_q - 1'b1;
      inflight_q <= inflight_q + cnt_t'(grant) - cnt_t'(rsp_live);
      if (push) begin
        out_mem_q[out_wr_q] <= push_data;
        out_wr_q            <= out_wr_q + 1'b1;
      end
      if (pop) out_rd_q <= out_rd_q + 1'b1;
      out_cnt_q <= out_cnt_q + cnt_t'(push) - cnt_t'(pop);
      carry_q   <= carry_n;
      off_q     <= off_n;
    end
  end

  assign busy_o = (inflight_q != '0) | (out_cnt_q != '0) | (drop_q != '0) | (state_q == ST_CARRY);

`ifdef HWPE_STREAM_FETCH_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                 stall_q <= '0;
    else if (clear_i)                            stall_q <= '0;
    else if (req & ~tcdm_gnt_i & (stall_q != '1)) stall_q <= stall_q + 1'b1;
  end
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_stream_tcdm_fetch_realign.sv
// Directed bench for hwpe_stream_tcdm_fetch_realign: token driver, TCDM responder and output monitor
// run in one loop; scenario tasks adjust controls at posedge+3 and check against hand-computed values.
module tb_hwpe_stream_tcdm_fetch_realign;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        test_mode = 1'b0;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic        gnt = 1'b1;
  logic        r_valid = 1'b0;
  logic [31:0] r_data = '0;
  logic        req, busy;
  logic [31:0] add, stall;

  hwpe_stream_intf_stream #(.DATA_WIDTH(36)) addr_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) data_if ();

  always #5 clk = ~clk;

  hwpe_stream_tcdm_fetch_realign #(.FIFO_DEPTH(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .test_mode_i    (test_mode),
    .enable_i       (enable),
    .clear_i        (clear),
    .addr_i         (addr_if),
    .tcdm_req_o     (req),
    .tcdm_gnt_i     (gnt),
    .tcdm_add_o     (add),
    .tcdm_r_data_i  (r_data),
    .tcdm_r_valid_i (r_valid),
    .data_o         (data_if),
    .busy_o         (busy),
    .stall_cnt_o    (stall)
  );

  typedef struct packed {
    logic [29:0] a;
    logic        mis;
    logic        first;
    logic        last;
    logic [3:0]  strb;
  } tok_t;

  tok_t        tok_q[$];
  logic [31:0] pend[$];
  logic [31:0] rx[$];
  int          rx_t[$];
  int          tok_idx = 0;
  int          cyc = 0;
  int          grants = 0;
  bit          rv_en = 1'b1;
  bit          spurious = 1'b0;
  int          checks = 0;
  int          errors = 0;

`ifdef HWPE_STREAM_FETCH_STALL_CNT_EN
  localparam logic [31:0] STALL_EXP = 32'd5;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  // TCDM content: byte at address x holds x[7:0]
  function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
    logic [7:0] b;
    b = byte_addr[7:0] & 8'hFC;
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  initial begin
    logic fa, ft, fo;
    logic [31:0] as, ds;
    addr_if.valid = 1'b0;
    addr_if.data  = '0;
    addr_if.strb  = '0;
    data_if.ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      fa = addr_if.valid & addr_if.ready;
      ft = req & gnt;
      as = add;
      fo = data_if.valid & data_if.ready;
      ds = data_if.data;
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (fa) tok_idx++;
        if (ft) begin
          pend.push_back(as);
          grants++;
        end
        if (fo) begin
          rx.push_back(ds);
          rx_t.push_back(cyc);
        end
      end
      if (tok_idx < tok_q.size()) begin
        addr_if.valid = 1'b1;
        addr_if.data  = {3'b000, tok_q[tok_idx].mis, tok_q[tok_idx].first, tok_q[tok_idx].last, tok_q[tok_idx].a};
        addr_if.strb  = tok_q[tok_idx].strb;
      end else begin
        addr_if.valid = 1'b0;
      end
      if (spurious) begin
        r_valid  = 1'b1;
        r_data   = 32'hDEADBEEF;
        spurious = 1'b0;
      end else if (rv_en && pend.size() > 0) begin
        r_valid = 1'b1;
        r_data  = mem_word(pend.pop_front());
      end else begin
        r_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic push_tok(input logic [29:0] a, input logic mis, input logic first,
                          input logic last, input logic [3:0] strb);
    tok_t t;
    t.a = a; t.mis = mis; t.first = first; t.last = last; t.strb = strb;
    tok_q.push_back(t);
  endtask

  task automatic wait_rx(input int n, input string name);
    for (int k = 0; k < 300 && rx.size() < n; k++) step();
    checks++;
    if (rx.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d words, expected %0d", name, rx.size(), n);
    end
  endtask

  task automatic test_reset();
    step();
    step();
    checks += 6;
    if (req !== 1'b0)           begin errors++; $display("FAIL rst_req: got %b expected 0", req); end
    if (add !== 32'h0)          begin errors++; $display("FAIL rst_add: got %h expected 0", add); end
    if (data_if.valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", data_if.valid); end
    if (data_if.data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", data_if.data); end
    if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (stall !== 32'h0)        begin errors++; $display("FAIL rst_stall: got %h expected 0", stall); end
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_idle: got req=%b busy=%b expected 0/0", req, busy);
    end
  endtask

  task automatic test_aligned();
    int base;
    base = rx.size();
    for (int i = 0; i < 8; i++) push_tok(30'h10 + 30'(i), 1'b0, 1'b0, 1'b0, 4'hF);
    wait_rx(base + 8, "aligned");
    for (int i = 0; i < 8 && base + i < rx.size(); i++) begin
      checks++;
      if (rx[base+i] !== mem_word(32'((32'h10 + i) * 4))) begin
        errors++;
        $display("FAIL aligned_word%0d: got %h expected %h", i, rx[base+i], mem_word(32'((32'h10 + i) * 4)));
      end
      if (i > 0) begin
        checks++;
        if (rx_t[base+i] - rx_t[base+i-1] != 1) begin
          errors++;
          $display("FAIL aligned_bubble%0d: got gap %0d expected 1", i, rx_t[base+i] - rx_t[base+i-1]);
        end
      end
    end
    repeat (3) step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL aligned_busy: got %b expected 0", busy); end
  endtask

  task automatic test_misaligned();
    int base;
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h04030201; exp_w[1] = 32'h08070605;
    exp_w[2] = 32'h0C0B0A09; exp_w[3] = 32'h100F0E0D;
    base = rx.size();
    push_tok(30'd0, 1'b1, 1'b1, 1'b0, 4'hE);
    push_tok(30'd1, 1'b1, 1'b0, 1'b0, 4'hF);
    push_tok(30'd2, 1'b1, 1'b0, 1'b0, 4'hF);
    push_tok(30'd3, 1'b1, 1'b0, 1'b0, 4'hF);
    push_tok(30'd4, 1'b1, 1'b0, 1'b1, 4'h1);
    wait_rx(base + 4, "misaligned");
    repeat (6) step();
    checks++;
    if (rx.size() != base + 4) begin
      errors++;
      $display("FAIL mis_count: got %0d expected 4", rx.size() - base);
    end
    for (int i = 0; i < 4 && base + i < rx.size(); i++) begin
      checks++;
      if (rx[base+i] !== exp_w[i]) begin
        errors++;
        $display("FAIL mis_word%0d: got %h expected %h", i, rx[base+i], exp_w[i]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mis_busy: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    int base, g0;
    base = rx.size();
    g0 = grants;
    data_if.ready = 1'b0;
    for (int i = 0; i < 10; i++) push_tok(30'h20 + 30'(i), 1'b0, 1'b0, 1'b0, 4'hF);
    repeat (20) step();
    checks += 3;
    if (grants - g0 != 4) begin errors++; $display("FAIL bp_grants: got %0d expected 4", grants - g0); end
    if (req !== 1'b0)     begin errors++; $display("FAIL bp_req: got %b expected 0", req); end
    if (rx.size() != base) begin errors++; $display("FAIL bp_leak: got %0d words expected 0", rx.size() - base); end
    data_if.ready = 1'b1;
    wait_rx(base + 10, "bp");
    for (int i = 0; i < 10 && base + i < rx.size(); i++) begin
      checks++;
      if (rx[base+i] !== mem_word(32'((32'h20 + i) * 4))) begin
        errors++;
        $display("FAIL bp_word%0d: got %h expected %h", i, rx[base+i], mem_word(32'((32'h20 + i) * 4)));
      end
    end
  endtask

  task automatic test_gnt_stall();
    int base;
    base = rx.size();
    gnt = 1'b0;
    push_tok(30'h30, 1'b0, 1'b0, 1'b0, 4'hF);
    for (int k = 0; k < 10 && !req; k++) step();
    for (int i = 0; i < 5; i++) begin
      checks += 2;
      if (addr_if.ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b expected 0", i, addr_if.ready); end
      if (add !== 32'h000000C0)   begin errors++; $display("FAIL stall_add%0d: got %h expected 000000c0", i, add); end
      step();
    end
    gnt = 1'b1;
    checks++;
    if (stall !== STALL_EXP) begin errors++; $display("FAIL stall_cnt: got %0d expected %0d", stall, STALL_EXP); end
    wait_rx(base + 1, "stall");
    checks++;
    if (rx.size() > base && rx[base] !== 32'hC3C2C1C0) begin
      errors++;
      $display("FAIL stall_word: got %h expected c3c2c1c0", rx[base]);
    end
  endtask

  task automatic test_clear();
    int base, g0;
    base = rx.size();
    g0 = grants;
    rv_en = 1'b0;
    for (int i = 0; i < 3; i++) push_tok(30'h40 + 30'(i), 1'b0, 1'b0, 1'b0, 4'hF);
    for (int k = 0; k < 20 && grants - g0 < 3; k++) step();
    step();
    clear = 1'b1;
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL clr_req_now: got %b expected 0", req); end
    step();
    clear = 1'b0;
    checks++;
    if (stall !== 32'h0) begin errors++; $display("FAIL clr_stall: got %0d expected 0", stall); end
    push_tok(30'h50, 1'b0, 1'b0, 1'b0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (req !== 1'b0) begin errors++; $display("FAIL clr_req_hold%0d: got %b expected 0", i, req); end
    end
    rv_en = 1'b1;
    wait_rx(base + 1, "clear");
    repeat (4) step();
    checks += 2;
    if (rx.size() != base + 1) begin
      errors++;
      $display("FAIL clr_count: got %0d words expected 1", rx.size() - base);
    end
    if (rx.size() > base && rx[base] !== 32'h43424140) begin
      errors++;
      $display("FAIL clr_word: got %h expected 43424140", rx[base]);
    end
    // stray read data with nothing outstanding must change nothing
    spurious = 1'b1;
    repeat (3) step();
    checks += 2;
    if (busy !== 1'b0)          begin errors++; $display("FAIL err_busy: got %b expected 0", busy); end
    if (data_if.valid !== 1'b0) begin errors++; $display("FAIL err_valid: got %b expected 0", data_if.valid); end
    base = rx.size();
    push_tok(30'h60, 1'b0, 1'b0, 1'b0, 4'hF);
    wait_rx(base + 1, "post_err");
    checks++;
    if (rx.size() > base && rx[base] !== 32'h83828180) begin
      errors++;
      $display("FAIL err_word: got %h expected 83828180", rx[base]);
    end
  endtask

  task automatic test_back_to_back();
    int base, g0, used, max_used;
    base = rx.size();
    g0 = grants;
    max_used = 0;
    for (int i = 0; i < 16; i++) push_tok(30'h70 + 30'(i), 1'b0, 1'b0, 1'b0, 4'hF);
    for (int k = 0; k < 300 && rx.size() < base + 16; k++) begin
      step();
      used = (grants - g0) - (rx.size() - base);
      if (used > max_used) max_used = used;
    end
    wait_rx(base + 16, "b2b");
    checks++;
    if (max_used > 4) begin errors++; $display("FAIL b2b_used: got %0d expected <=4", max_used); end
    for (int i = 0; i < 16 && base + i < rx.size(); i++) begin
      checks++;
      if (rx[base+i] !== mem_word(32'((32'h70 + i) * 4))) begin
        errors++;
        $display("FAIL b2b_word%0d: got %h expected %h", i, rx[base+i], mem_word(32'((32'h70 + i) * 4)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_misaligned();
    test_backpressure();
    test_gnt_stall();
    test_clear();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
